// File: rtl/popcount_pkg.sv
// Shared width helpers and default geometry for the streaming popcount accumulator.
package popcount_pkg;

    localparam int unsigned DEF_IN_W    = 32;
    localparam int unsigned DEF_CHUNK_W = 8;

    // Bits needed to hold a count of 0..n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned nchunk(input int unsigned in_w, input int unsigned chunk_w);
        return (in_w + chunk_w - 1) / chunk_w;
    endfunction

    localparam int unsigned NCHUNK     = nchunk(DEF_IN_W, DEF_CHUNK_W);
    localparam int unsigned BEAT_CNT_W = cnt_w(DEF_IN_W);

endpackage

// File: rtl/popcount_chunk.sv
// Combinational ones-counter for one W-bit chunk of a data beat.
module popcount_chunk
    import popcount_pkg::*;
#(
    parameter int unsigned W = DEF_CHUNK_W
) (
    input  logic [W-1:0]        bits,
    output logic [cnt_w(W)-1:0] cnt_c
);

    localparam int unsigned CW = cnt_w(W);

    always_comb begin
        cnt_c = '0;
        for (int i = 0; i < int'(W); i++) begin
            cnt_c = cnt_c + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/popcount_stream_acc.sv
// Two-stage streaming popcount with per-frame accumulation and valid/ready result.
// Optional saturation of count/beats plus sticky overflow flag: define POPCNT_SAT_EN.
module popcount_stream_acc
    import popcount_pkg::*;
#(
    parameter int unsigned IN_W    = DEF_IN_W,
    parameter int unsigned CHUNK_W = DEF_CHUNK_W,
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned BEAT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_count,
    output logic [BEAT_W-1:0] out_beats,
    output logic              out_ovf
);

    localparam int unsigned N_CHUNK     = nchunk(IN_W, CHUNK_W);
    localparam int unsigned PAD_W       = N_CHUNK * CHUNK_W;
    localparam int unsigned CHUNK_CNT_W = cnt_w(CHUNK_W);
    localparam int unsigned SUM_W       = cnt_w(IN_W);

    logic                                   stall_c;
    logic [PAD_W-1:0]                       data_pad_c;
    logic [N_CHUNK-1:0][CHUNK_CNT_W-1:0]    chunk_cnt_c;
    logic [N_CHUNK-1:0][CHUNK_CNT_W-1:0]    s1_cnt;
    logic                                   s1_valid;
    logic                                   s1_last;
    logic [SUM_W-1:0]                       beat_cnt_c;
    logic [ACC_W-1:0]                       acc;
    logic [BEAT_W-1:0]                      beats;
    logic [ACC_W-1:0]                       acc_next_c;
    logic [BEAT_W-1:0]                      beats_next_c;

    // Whole pipeline freezes while a finished result waits for the consumer.
    assign stall_c    = out_valid && !out_ready;
    assign in_ready   = !stall_c;
    assign data_pad_c = PAD_W'(in_data);

    for (genvar g = 0; g < int'(N_CHUNK); g++) begin : g_chunk
        popcount_chunk #(.W(CHUNK_W)) u_chunk (
            .bits  (data_pad_c[g*CHUNK_W +: CHUNK_W]),
            .cnt_c (chunk_cnt_c[g])
        );
    end

    always_comb begin
        beat_cnt_c = '0;
        for (int i = 0; i < int'(N_CHUNK); i++) begin
            beat_cnt_c = beat_cnt_c + SUM_W'(s1_cnt[i]);
        end
    end

`ifdef POPCNT_SAT_EN
    logic [ACC_W:0] acc_sum_c;
    logic           ovf_acc;
    logic           ovf_next_c;

    assign acc_sum_c = {1'b0, acc} + (ACC_W+1)'(beat_cnt_c);

    always_comb begin
        acc_next_c   = acc_sum_c[ACC_W] ? '1 : acc_sum_c[ACC_W-1:0];
        beats_next_c = (&beats) ? beats : beats + BEAT_W'(1);
        ovf_next_c   = ovf_acc | acc_sum_c[ACC_W];
    end

    // Overflow is sticky across the frame and reported with its result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_acc <= 1'b0;
            out_ovf <= 1'b0;
        end else if (!stall_c && s1_valid) begin
            if (s1_last) begin
                out_ovf <= ovf_next_c;
                ovf_acc <= 1'b0;
            end else begin
                ovf_acc <= ovf_next_c;
            end
        end
    end
`else
    assign acc_next_c   = acc + ACC_W'(beat_cnt_c);
    assign beats_next_c = beats + BEAT_W'(1);
    assign out_ovf      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_cnt    <= '0;
            acc       <= '0;
            beats     <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_beats <= '0;
        end else if (!stall_c) begin
            s1_valid  <= in_valid;
            s1_last   <= in_last;
            s1_cnt    <= chunk_cnt_c;
            out_valid <= s1_valid && s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    out_count <= acc_next_c;
                    out_beats <= beats_next_c;
                    acc       <= '0;
                    beats     <= '0;
                end else begin
                    acc       <= acc_next_c;
                    beats     <= beats_next_c;
                end
            end
        end
    end

endmodule

// File: doc/popcount_stream_acc.md
Name: popcount_stream_acc

Overview:
- Streaming, pipelined population counter for arbitrary IN_W-bit data beats.
- Accumulates the ones-count over a multi-beat frame delimited by in_last.
- Emits the per-frame total and beat count on a valid/ready output.
- Generalised, registered successor of the team's fixed 32-input combinational ones-counter; used in the AQFP/ISCAS benchmark datapaths wherever counts span several words.

Parameters:
- IN_W, 32, data beat width in bits; IN_W >= 1.
- CHUNK_W, 8, bits per first-stage chunk counter; IN_W need not be a multiple (last chunk zero-padded).
- ACC_W, 16, frame accumulator / out_count width; ACC_W >= clog2(IN_W+1).
- BEAT_W, 8, frame beat counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  IN_W  beat to be counted.
- in_last  in  1  beat is final of frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts result.
- out_count  out  ACC_W  total ones in frame.
- out_beats  out  BEAT_W  beats in frame, including the last beat.
- out_ovf  out  1  accumulator saturated; only driven with the optional feature, otherwise constant 0.

Behaviour:
- Reset (async, any time, including mid-frame):
  - All pipeline valids, accumulator, beat counter, out_valid, out_count, out_beats and out_ovf cleared to 0.
  - in_ready is 1 on the first edge after rst deasserts.
  - A partial frame is discarded.
- Accept: a beat transfers when in_valid && in_ready.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - During stall, every pipeline register and the accumulator hold; no beat is dropped or duplicated.
- S1 (cycle after accept):
  - Registers per-chunk counts (each clog2(CHUNK_W+1) bits), last flag and valid.
  - One popcount_chunk instance per chunk.
- S2 (next cycle):
  - Sums the chunk counts into beat_cnt (clog2(IN_W+1) bits).
  - Not last: acc <= acc + beat_cnt; beats <= beats + 1.
  - Last: out_count <= acc + beat_cnt; out_beats <= beats + 1; out_valid <= 1; acc and beats cleared to 0 in the same cycle, so the next frame starts clean.
- Latency: out_valid rises 2 cycles after acceptance of the last beat.
- Throughput: one beat per cycle. Back-to-back single-beat frames give one result per cycle when out_ready = 1.
- Output handshake: out_valid stays high and out_* stay stable until out_valid && out_ready. A new result may load in the same cycle the old one is consumed.
- Overflow, without the optional feature:
  - acc wraps modulo 2^ACC_W.
  - beats wraps modulo 2^BEAT_W.
  - out_ovf = 0.
- Empty data: an all-zero beat counts as 0 but still increments beats.
- Frame state machine (implicit): IDLE (acc = 0, beats = 0) -> ACCUM on a non-last beat -> IDLE on the last beat. A single-beat frame goes IDLE -> IDLE.

Optional Feature:
- Macro: POPCNT_SAT_EN.
- Defined:
  - acc and out_count saturate at 2^ACC_W-1.
  - out_ovf is set with the result if saturation occurred anywhere in the frame; sticky per frame, cleared with acc.
  - beats saturates at 2^BEAT_W-1.
- Undefined: wrap-around as above; out_ovf tied 0; no saturation logic synthesised.

Decomposition:
- popcount_pkg holds:
  - Width helper function cnt_w(n) = clog2(n+1).
  - Derived constants NCHUNK = ceil(IN_W/CHUNK_W) and BEAT_CNT_W = cnt_w(IN_W).
  - Default CHUNK_W constant.
- One sub-module, popcount_chunk: combinational CHUNK_W-bit ones-counter, parametrised by width, output cnt_w(CHUNK_W) bits. The top instantiates NCHUNK copies.

Test Plan:
- Single beat: in_data = 0xFFFFFFFF, last = 1, out_ready = 1 -> out_valid exactly 2 cycles later; out_count = 32; out_beats = 1.
- Multi-beat frame: 0xFFFFFFFF, 0x0000000F, 0x80000001 (last on third beat) -> out_count = 38; out_beats = 3; the next single-beat frame 0x00000003 -> out_count = 2.
- Backpressure: hold out_ready = 0 for 5 cycles while streaming -> in_ready = 0, out_* stable; after release every frame result appears once, in order.
- Streaming: 10 back-to-back single-beat frames, patterns 0x1, 0x3, ... 0x3FF, out_ready = 1 -> one result per cycle, counts 1..10.
- Reset mid-frame: two non-last beats of 0xFF, assert rst, then one beat 0x1 with last -> out_count = 1, out_beats = 1.
- ACC_W = 6, two beats of 0xFFFFFFFF, last on second:
  - Without POPCNT_SAT_EN -> out_count = 0, out_ovf = 0.
  - With POPCNT_SAT_EN -> out_count = 63, out_ovf = 1.
